// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the line-control word-length encoding, the transmit FSM state type,
// the default oversample ratio and the parity/stop-length helper functions.
package uart_pkg;

  // Default number of baud_pulse ticks per bit period (16x oversample).
  localparam int OVERSAMPLE_DEF = 16;

  // Word length select encoding (LCR[1:0]).
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Parity over the active word only; bits above the word length are masked.
  // sticky: parity bit is the inverse of eps regardless of data.
  // eps=1: even parity (XOR), eps=0: odd parity (XNOR).
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       eps,
                                       input logic       sticky);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - wls);
    x    = ^(data & mask);
    if (sticky) begin
      return ~eps;
    end else if (eps) begin
      return x;
    end else begin
      return ~x;
    end
  endfunction

  // Stop period length in baud_pulse ticks: 1, 1.5 (5-bit words) or 2 bits.
  function automatic int stop_ticks(input logic       stb,
                                    input logic [1:0] wls,
                                    input int         oversample);
    if (!stb) begin
      return oversample;
    end else if (wls == WLS_5) begin
      return oversample + oversample / 2;
    end else begin
      return 2 * oversample;
    end
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 16550-style UART transmit serializer, LSB first, with optional
//   parity, 1/1.5/2 stop bits and break. Frame bits change only on baud_pulse.
// Latency: tx falls on the same baud_pulse edge that loads a byte; pop follows
//   that edge for one clk. Backpressure: a byte is taken only when fifo_empty=0
//   and the serializer is idle or finishing a stop period (back-to-back frames).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   baud_pulse        - one-clk strobe at OVERSAMPLE x baud
//   fifo_empty, din   - show-ahead TX FIFO status and head byte
//   pop               - one-clk pulse advancing the FIFO head
//   wls, stb, pen,
//   eps, sticky_parity- line control, sampled at each byte load
//   set_break         - force tx low while the FSM keeps running
//   tx                - serial output, idle high
//   sreg_empty        - high when no frame is in progress
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] din,
  output logic              pop,
  input  logic [1:0]        wls,
  input  logic              stb,
  input  logic              pen,
  input  logic              eps,
  input  logic              sticky_parity,
  input  logic              set_break,
  output logic              tx,
  output logic              sreg_empty
);

  // The tick counter must reach the longest period: two stop bits.
  localparam int TICK_W = $clog2(2 * OVERSAMPLE);

  // Tick value seen on the last baud_pulse of a normal bit period.
  localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(OVERSAMPLE - 1);

  tx_state_t          state;
  logic [TICK_W-1:0]  tick;
  logic [2:0]         bit_cnt;
  logic [DATA_W-1:0]  shreg;

  // Frame configuration, frozen at load so mid-frame line-control writes
  // only affect the next frame. Parity and stop length are resolved at load
  // from the byte and config, which is all they depend on.
  logic [1:0]         cfg_wls;
  logic               cfg_pen;
  logic               parity_bit;
  logic [TICK_W-1:0]  stop_last;

  logic               tx_int;
  logic               break_q;
  logic               load;
  logic               bit_end;
  logic [2:0]         last_bit;

  // Index of the final data bit: 4..7 for word lengths 5..8.
  assign last_bit = {1'b1, cfg_wls};

  // Last tick of the current data/start/parity bit period.
  assign bit_end = baud_pulse && (tick == BIT_LAST);

  // A byte is loaded from idle, or straight out of the final stop tick so
  // that consecutive frames have no idle gap between them.
  always_comb begin
    load = 1'b0;
    if (baud_pulse && !fifo_empty) begin
      if (state == TX_IDLE) begin
        load = 1'b1;
      end else if ((state == TX_STOP) && (tick == stop_last)) begin
        load = 1'b1;
      end
    end
  end

  // Break overrides the line without disturbing the serializer.
  assign tx = tx_int & ~break_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cfg_wls    <= WLS_8;
      cfg_pen    <= 1'b0;
      parity_bit <= 1'b0;
      stop_last  <= BIT_LAST;
      tx_int     <= 1'b1;
      break_q    <= 1'b0;
      pop        <= 1'b0;
      sreg_empty <= 1'b1;
    end else begin
      pop     <= 1'b0;
      break_q <= set_break;

      if (load) begin
        // The load pulse itself counts as the first tick of the start bit.
        shreg      <= din;
        cfg_wls    <= wls;
        cfg_pen    <= pen;
        parity_bit <= calc_parity(8'(din), wls, eps, sticky_parity);
        stop_last  <= TICK_W'(stop_ticks(stb, wls, OVERSAMPLE) - 1);
        tx_int     <= 1'b0;
        pop        <= 1'b1;
        sreg_empty <= 1'b0;
        tick       <= '0;
        bit_cnt    <= '0;
        state      <= TX_START;
      end else if (baud_pulse) begin
        case (state)
          TX_IDLE: begin
            tx_int     <= 1'b1;
            sreg_empty <= 1'b1;
          end

          TX_START: begin
            if (bit_end) begin
              tick   <= '0;
              tx_int <= shreg[0];
              shreg  <= shreg >> 1;
              state  <= TX_DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end

          TX_DATA: begin
            if (bit_end) begin
              tick <= '0;
              if (bit_cnt == last_bit) begin
                if (cfg_pen) begin
                  tx_int <= parity_bit;
                  state  <= TX_PARITY;
                end else begin
                  tx_int <= 1'b1;
                  state  <= TX_STOP;
                end
              end else begin
                tx_int  <= shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          TX_PARITY: begin
            if (bit_end) begin
              tick   <= '0;
              tx_int <= 1'b1;
              state  <= TX_STOP;
            end else begin
              tick <= tick + 1'b1;
            end
          end

          TX_STOP: begin
            // Reaching stop_last here means the FIFO was empty (else load).
            if (tick == stop_last) begin
              tick       <= '0;
              sreg_empty <= 1'b1;
              state      <= TX_IDLE;
            end else begin
              tick <= tick + 1'b1;
            end
          end

          default: begin
            tick       <= '0;
            tx_int     <= 1'b1;
            sreg_empty <= 1'b1;
            state      <= TX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- 16550-style UART transmit serializer; the transmit counterpart of the existing UART receiver.
- Shares the same 16x oversample `baud_pulse` and line-control fields: `wls`, `pen`, `eps`, `sticky_parity`.
- Pops bytes from an upstream show-ahead TX FIFO and drives the serial `tx` line, LSB first.
- Supports start, data, optional parity and stop bits, plus break.

Parameters:
- OVERSAMPLE, 16, `baud_pulse` ticks per bit period; must be even and ≥ 4.
- DATA_W, 8, maximum data width; `wls` selects 5..8 of these bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_pulse  in  1  one-clk strobe at 16x baud rate
- fifo_empty  in  1  upstream TX FIFO empty; when low, `din` is valid (show-ahead)
- din  in  8  head-of-FIFO byte
- pop  out  1  one-clk pulse; FIFO advances its head
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  in  1  0 = 1 stop bit; 1 = 2 stop bits, or 1.5 stop bits when wls=00
- pen  in  1  parity enable
- eps  in  1  even parity select
- sticky_parity  in  1  stick parity
- set_break  in  1  force line low
- tx  out  1  serial output, idle high
- sreg_empty  out  1  high when no frame is in progress (TEMT)

Behaviour:
- Reset (asynchronous, immediate, any state including mid-frame):
  - state=IDLE, tx=1, pop=0, sreg_empty=1.
  - Tick counter and bit counter cleared; the partial frame is abandoned and no pop is issued.
- All outputs are registered; `tx` changes only on `clk` edges where `baud_pulse`=1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, sreg_empty=1.
  - On an edge with baud_pulse=1 and fifo_empty=0:
    - capture din into the shift register;
    - capture wls/stb/pen/eps/sticky_parity into frame-config registers;
    - pop=1 for exactly that next cycle; tx<=0; sreg_empty<=0; tick=0; go to START.
  - If fifo_empty=1, remain in IDLE; pop is never asserted while fifo_empty=1.
- START: hold tx=0 for OVERSAMPLE baud_pulses. At the end, tx<=data[0] and go to DATA.
- DATA:
  - Each bit is held for OVERSAMPLE pulses, then shift right.
  - After the last bit (index 4/5/6/7 for latched wls 00/01/10/11):
    - if pen=1, go to PARITY;
    - otherwise set tx<=1 and go to STOP.
- Parity bit value, computed over the latched word only (bits above the word length are excluded):
  - sticky_parity=1: parity = ~eps.
  - else eps=1 (even): parity = XOR of data bits.
  - else (odd): parity = XNOR of data bits.
- PARITY: hold the parity bit for OVERSAMPLE pulses, then set tx<=1 and go to STOP.
- STOP:
  - Length is OVERSAMPLE pulses (stb=0), 2×OVERSAMPLE (stb=1, wls≠00), or 1.5×OVERSAMPLE (stb=1, wls=00).
  - At the end:
    - if fifo_empty=0, load the next byte exactly as from IDLE (back-to-back frames, no idle gap);
    - otherwise go to IDLE with sreg_empty<=1.
- Configuration changes mid-frame do not affect the current frame; they take effect at the next load.
- set_break:
  - tx output = tx_int & ~set_break, combinationally from registered tx_int and a registered set_break copy.
  - The FSM keeps running, so frames are consumed while break is active.
- A tick count of 0 at load means the first bit spans exactly OVERSAMPLE baud_pulses including the load pulse.

Decomposition:
- Shared package `uart_pkg`:
  - wls encoding constants;
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE_DEF` = 16;
  - parity function `calc_parity(data, wls, eps, sticky)`, also usable by the receiver.
- No sub-module; single FSM with tick and bit counters.

Test Plan:
1. Odd parity, 8 data, 1 stop: wls=11, pen=1, eps=0, stb=0, din=0x45, baud_pulse every 6 clk.
   → one pop; tx = 0,1,0,1,0,0,0,1,0 then parity=0, stop=1, each bit 96 clk; sreg_empty returns 1 after 11×96 clk.
2. Even parity, 7 data, 2 stop: wls=10, pen=1, eps=1, stb=1, din=0xFF.
   → 7 ones, parity=1, stop high for 192 clk; bit 7 is never transmitted.
3. Back-to-back frames: FIFO holds 0x00,0xA5, no parity.
   → two pops, 10×96 clk apart; the second start bit immediately follows the first stop bit; no extra idle.
4. Short word, 1.5 stop, stick parity: wls=00, stb=1, pen=1, sticky_parity=1, eps=1.
   → 5 data bits, parity=0, stop lasts exactly 24 baud_pulses.
5. Break and reset: assert set_break mid-frame → tx=0 next cycle while the FSM advances; assert rst mid-DATA.
   → tx=1, pop=0, sreg_empty=1 immediately; the FIFO head is not re-popped.
6. Empty FIFO: fifo_empty=1 for 1000 clk → pop never asserted, tx=1, sreg_empty=1.
